// File: rtl/pin_entry_ctrl.sv
// pin_entry_ctrl: keypad PIN entry controller for the digital lock.
// Collects digit keys into a BCD buffer, compares against the stored PIN on
// enter, pulses grant/deny, and locks the keypad out after repeated failures.
// Every output comes straight from a register; next values are computed in a
// single combinational block from the current state and the key strobe.
module pin_entry_ctrl #(
    parameter int PIN_LEN        = 4,
    parameter int MAX_TRIES      = 3,
    parameter int LOCK_CYCLES    = 1000,
    parameter int TIMEOUT_CYCLES = 500
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         key_valid,
    input  logic [3:0]                   key_code,
    input  logic                         setup_on,
    input  logic [4*PIN_LEN-1:0]         pin_ref,
    output logic [4*PIN_LEN-1:0]         digits,
    output logic [$clog2(PIN_LEN+1)-1:0] digit_count,
    output logic                         bcd_enable,
    output logic                         bip,
    output logic                         grant,
    output logic                         deny,
    output logic                         locked_out
);

    localparam int CNT_W   = $clog2(PIN_LEN + 1);
    localparam int TRY_W   = $clog2(MAX_TRIES + 1);
    localparam int TMR_MAX = (LOCK_CYCLES > TIMEOUT_CYCLES) ? LOCK_CYCLES : TIMEOUT_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX);

    localparam logic [CNT_W-1:0] CNT_FULL     = CNT_W'(PIN_LEN);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [TRY_W-1:0] TRY_LIMIT    = TRY_W'(MAX_TRIES);
    localparam logic [TRY_W-1:0] TRY_ONE      = TRY_W'(1);
    localparam logic [TMR_W-1:0] TMR_ONE      = TMR_W'(1);
    localparam logic [TMR_W-1:0] LOCK_LAST    = TMR_W'(LOCK_CYCLES - 1);
    localparam logic [TMR_W-1:0] TIMEOUT_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    localparam logic [3:0] KEY_ENTER = 4'hE;
    localparam logic [3:0] KEY_CLEAR = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ENTRY   = 2'd1,
        ST_CHECK   = 2'd2,
        ST_LOCKOUT = 2'd3
    } state_t;

    // Key classification: 0x0-0x9 are digits, 0xA-0xD carry no meaning.
    function automatic logic is_digit(input logic [3:0] code);
        return (code <= 4'h9);
    endfunction

    state_t                 state_r,    state_nx_s;
    logic [4*PIN_LEN-1:0]   digits_r,   digits_nx_s;
    logic [CNT_W-1:0]       count_r,    count_nx_s;
    logic [TRY_W-1:0]       try_r,      try_nx_s;
    logic [TRY_W-1:0]       try_inc_s;
    logic [TMR_W-1:0]       tmr_r,      tmr_nx_s;
    logic                   bip_r,      bip_nx_s;
    logic                   grant_r,    grant_nx_s;
    logic                   deny_r,     deny_nx_s;
    logic                   bcd_r,      bcd_nx_s;
    logic                   lock_r,     lock_nx_s;
    logic                   key_acc_s;
    logic                   match_s;

    assign match_s   = (count_r == CNT_FULL) && (digits_r == pin_ref);
    assign try_inc_s = try_r + TRY_ONE;

    // Next-state and next-output computation for the whole controller.
    always_comb begin
        state_nx_s  = state_r;
        digits_nx_s = digits_r;
        count_nx_s  = count_r;
        try_nx_s    = try_r;
        tmr_nx_s    = tmr_r;
        bip_nx_s    = 1'b0;
        grant_nx_s  = 1'b0;
        deny_nx_s   = 1'b0;
        key_acc_s   = 1'b0;

        if (setup_on && (state_r != ST_LOCKOUT)) begin
            // Setup owns the stored PIN: drop entry, suppress any verdict.
            state_nx_s  = ST_IDLE;
            digits_nx_s = '0;
            count_nx_s  = '0;
            tmr_nx_s    = '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    tmr_nx_s = '0;
                    if (key_valid && is_digit(key_code)) begin
                        digits_nx_s      = '0;
                        digits_nx_s[3:0] = key_code;
                        count_nx_s       = CNT_ONE;
                        bip_nx_s         = 1'b1;
                        state_nx_s       = ST_ENTRY;
                    end else begin
                        state_nx_s = ST_IDLE;
                    end
                end

                ST_ENTRY: begin
                    if (key_valid) begin
                        if (is_digit(key_code)) begin
                            if (count_r < CNT_FULL) begin
                                digits_nx_s      = digits_r << 3'd4;
                                digits_nx_s[3:0] = key_code;
                                count_nx_s       = count_r + CNT_ONE;
                                bip_nx_s         = 1'b1;
                                key_acc_s        = 1'b1;
                            end else begin
                                key_acc_s = 1'b0;
                            end
                        end else if (key_code == KEY_CLEAR) begin
                            digits_nx_s = '0;
                            count_nx_s  = '0;
                            bip_nx_s    = 1'b1;
                            state_nx_s  = ST_IDLE;
                            key_acc_s   = 1'b1;
                        end else if (key_code == KEY_ENTER) begin
                            bip_nx_s   = 1'b1;
                            state_nx_s = ST_CHECK;
                            key_acc_s  = 1'b1;
                        end else begin
                            key_acc_s = 1'b0;
                        end
                    end else begin
                        key_acc_s = 1'b0;
                    end

                    // Inactivity timer restarts on any accepted key.
                    if (key_acc_s) begin
                        tmr_nx_s = '0;
                    end else if (tmr_r == TIMEOUT_LAST) begin
                        tmr_nx_s    = '0;
                        digits_nx_s = '0;
                        count_nx_s  = '0;
                        state_nx_s  = ST_IDLE;
                    end else begin
                        tmr_nx_s = tmr_r + TMR_ONE;
                    end
                end

                ST_CHECK: begin
                    tmr_nx_s    = '0;
                    digits_nx_s = '0;
                    count_nx_s  = '0;
                    if (match_s) begin
                        grant_nx_s = 1'b1;
                        try_nx_s   = '0;
                        state_nx_s = ST_IDLE;
                    end else begin
                        deny_nx_s = 1'b1;
                        try_nx_s  = try_inc_s;
                        if (try_inc_s == TRY_LIMIT) begin
                            state_nx_s = ST_LOCKOUT;
                        end else begin
                            state_nx_s = ST_IDLE;
                        end
                    end
                end

                ST_LOCKOUT: begin
                    if (tmr_r == LOCK_LAST) begin
                        tmr_nx_s   = '0;
                        try_nx_s   = '0;
                        state_nx_s = ST_IDLE;
                    end else begin
                        tmr_nx_s = tmr_r + TMR_ONE;
                    end
                end

                default: begin
                    state_nx_s  = ST_IDLE;
                    digits_nx_s = '0;
                    count_nx_s  = '0;
                    tmr_nx_s    = '0;
                end
            endcase
        end

        // Level outputs follow the state being entered so they stay registered.
        bcd_nx_s  = (state_nx_s == ST_ENTRY);
        lock_nx_s = (state_nx_s == ST_LOCKOUT);
    end

    // State and output registers, cleared asynchronously by the active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r  <= ST_IDLE;
            digits_r <= '0;
            count_r  <= '0;
            try_r    <= '0;
            tmr_r    <= '0;
            bip_r    <= 1'b0;
            grant_r  <= 1'b0;
            deny_r   <= 1'b0;
            bcd_r    <= 1'b0;
            lock_r   <= 1'b0;
        end else begin
            state_r  <= state_nx_s;
            digits_r <= digits_nx_s;
            count_r  <= count_nx_s;
            try_r    <= try_nx_s;
            tmr_r    <= tmr_nx_s;
            bip_r    <= bip_nx_s;
            grant_r  <= grant_nx_s;
            deny_r   <= deny_nx_s;
            bcd_r    <= bcd_nx_s;
            lock_r   <= lock_nx_s;
        end
    end

    assign digits      = digits_r;
    assign digit_count = count_r;
    assign bcd_enable  = bcd_r;
    assign bip         = bip_r;
    assign grant       = grant_r;
    assign deny        = deny_r;
    assign locked_out  = lock_r;

endmodule

// File: tb/tb_pin_entry_ctrl.sv
// tb_pin_entry_ctrl: directed table-driven bench for pin_entry_ctrl.
// Each vector drives one cycle of inputs and states the outputs expected
// just after the following rising edge; multi-cycle corners are hand-written.
module tb_pin_entry_ctrl;

    localparam int PIN_LEN        = 4;
    localparam int MAX_TRIES      = 3;
    localparam int LOCK_CYCLES    = 40;
    localparam int TIMEOUT_CYCLES = 25;

    logic        clk       = 1'b0;
    logic        rst       = 1'b0;
    logic        key_valid = 1'b0;
    logic [3:0]  key_code  = 4'h0;
    logic        setup_on  = 1'b0;
    logic [15:0] pin_ref   = 16'h1234;
    logic [15:0] digits;
    logic [2:0]  digit_count;
    logic        bcd_enable;
    logic        bip;
    logic        grant;
    logic        deny;
    logic        locked_out;

    int checks = 0;
    int errors = 0;

    // 100 MHz-style free-running clock.
    always #5 clk = ~clk;

    pin_entry_ctrl #(
        .PIN_LEN        (PIN_LEN),
        .MAX_TRIES      (MAX_TRIES),
        .LOCK_CYCLES    (LOCK_CYCLES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .setup_on    (setup_on),
        .pin_ref     (pin_ref),
        .digits      (digits),
        .digit_count (digit_count),
        .bcd_enable  (bcd_enable),
        .bip         (bip),
        .grant       (grant),
        .deny        (deny),
        .locked_out  (locked_out)
    );

    // flg packs the expected {bip, grant, deny, locked_out, bcd_enable}.
    typedef struct {
        logic        kv;
        logic [3:0]  code;
        logic        su;
        logic [4:0]  flg;
        logic [2:0]  cnt;
        logic [15:0] dig;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic kv, input logic [3:0] code, input logic su,
                                input logic [4:0] flg, input logic [2:0] cnt, input logic [15:0] dig);
        vec_t v;
        v.kv = kv; v.code = code; v.su = su; v.flg = flg; v.cnt = cnt; v.dig = dig;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic apply_vec(input vec_t x, input string name);
        key_valid = x.kv;
        key_code  = x.code;
        setup_on  = x.su;
        @(posedge clk);
        #1;
        check(name, 32'({bip, grant, deny, locked_out, bcd_enable, digit_count, digits}),
                    32'({x.flg, x.cnt, x.dig}));
    endtask

    task automatic good_pin(input string name);
        apply_vec(mk(1'b1, 4'h1, 1'b0, 5'b10001, 3'd1, 16'h0001), {name, "_d1"});
        apply_vec(mk(1'b1, 4'h2, 1'b0, 5'b10001, 3'd2, 16'h0012), {name, "_d2"});
        apply_vec(mk(1'b1, 4'h3, 1'b0, 5'b10001, 3'd3, 16'h0123), {name, "_d3"});
        apply_vec(mk(1'b1, 4'h4, 1'b0, 5'b10001, 3'd4, 16'h1234), {name, "_d4"});
        apply_vec(mk(1'b1, 4'hE, 1'b0, 5'b10000, 3'd4, 16'h1234), {name, "_enter"});
        apply_vec(mk(1'b0, 4'h0, 1'b0, 5'b01000, 3'd0, 16'h0000), {name, "_grant"});
    endtask

    task automatic wrong_pin(input string name, input logic lock_exp);
        apply_vec(mk(1'b1, 4'h5, 1'b0, 5'b10001, 3'd1, 16'h0005), {name, "_d1"});
        apply_vec(mk(1'b1, 4'h6, 1'b0, 5'b10001, 3'd2, 16'h0056), {name, "_d2"});
        apply_vec(mk(1'b1, 4'h7, 1'b0, 5'b10001, 3'd3, 16'h0567), {name, "_d3"});
        apply_vec(mk(1'b1, 4'h8, 1'b0, 5'b10001, 3'd4, 16'h5678), {name, "_d4"});
        apply_vec(mk(1'b1, 4'hE, 1'b0, 5'b10000, 3'd4, 16'h5678), {name, "_enter"});
        apply_vec(mk(1'b0, 4'h0, 1'b0, {3'b001, lock_exp, 1'b0}, 3'd0, 16'h0000), {name, "_deny"});
    endtask

    // Called just after a rising edge; reset lands between edges.
    task automatic async_reset(input string name);
        key_valid = 1'b0;
        setup_on  = 1'b0;
        #3 rst = 1'b0;
        #1 check({name, "_immediate"},
                 32'({bip, grant, deny, locked_out, bcd_enable, digit_count, digits}), 32'd0);
        @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Hard bound on total run time.
    initial begin
        #100000;
        $display("FAIL watchdog: run did not complete within the time limit");
        $fatal(1, "watchdog expired");
    end

    // Main directed sequence.
    initial begin
        int   n;
        logic quiet;

        // Correct PIN, fifth digit ignored, grant two cycles after enter.
        vecs.push_back(mk(1'b1, 4'h1, 1'b0, 5'b10001, 3'd1, 16'h0001));
        vecs.push_back(mk(1'b1, 4'h2, 1'b0, 5'b10001, 3'd2, 16'h0012));
        vecs.push_back(mk(1'b1, 4'h3, 1'b0, 5'b10001, 3'd3, 16'h0123));
        vecs.push_back(mk(1'b1, 4'h4, 1'b0, 5'b10001, 3'd4, 16'h1234));
        vecs.push_back(mk(1'b1, 4'h5, 1'b0, 5'b00001, 3'd4, 16'h1234));
        vecs.push_back(mk(1'b1, 4'hE, 1'b0, 5'b10000, 3'd4, 16'h1234));
        vecs.push_back(mk(1'b0, 4'h0, 1'b0, 5'b01000, 3'd0, 16'h0000));
        vecs.push_back(mk(1'b0, 4'h0, 1'b0, 5'b00000, 3'd0, 16'h0000));
        // Short PIN: deny, buffer cleared (try count becomes 1).
        vecs.push_back(mk(1'b1, 4'h1, 1'b0, 5'b10001, 3'd1, 16'h0001));
        vecs.push_back(mk(1'b1, 4'h2, 1'b0, 5'b10001, 3'd2, 16'h0012));
        vecs.push_back(mk(1'b1, 4'h3, 1'b0, 5'b10001, 3'd3, 16'h0123));
        vecs.push_back(mk(1'b1, 4'hE, 1'b0, 5'b10000, 3'd3, 16'h0123));
        vecs.push_back(mk(1'b0, 4'h0, 1'b0, 5'b00100, 3'd0, 16'h0000));
        vecs.push_back(mk(1'b0, 4'h0, 1'b0, 5'b00000, 3'd0, 16'h0000));
        // Clear key, enter/clear/ignored keys in IDLE, ignored key in ENTRY.
        vecs.push_back(mk(1'b1, 4'h9, 1'b0, 5'b10001, 3'd1, 16'h0009));
        vecs.push_back(mk(1'b1, 4'hF, 1'b0, 5'b10000, 3'd0, 16'h0000));
        vecs.push_back(mk(1'b1, 4'hE, 1'b0, 5'b00000, 3'd0, 16'h0000));
        vecs.push_back(mk(1'b1, 4'hA, 1'b0, 5'b00000, 3'd0, 16'h0000));
        vecs.push_back(mk(1'b1, 4'hF, 1'b0, 5'b00000, 3'd0, 16'h0000));
        vecs.push_back(mk(1'b1, 4'h5, 1'b0, 5'b10001, 3'd1, 16'h0005));
        vecs.push_back(mk(1'b1, 4'hA, 1'b0, 5'b00001, 3'd1, 16'h0005));
        vecs.push_back(mk(1'b1, 4'hF, 1'b0, 5'b10000, 3'd0, 16'h0000));
        // setup_on mid-entry clears buffer; keys ignored while it is high.
        vecs.push_back(mk(1'b1, 4'h3, 1'b0, 5'b10001, 3'd1, 16'h0003));
        vecs.push_back(mk(1'b1, 4'h4, 1'b0, 5'b10001, 3'd2, 16'h0034));
        vecs.push_back(mk(1'b1, 4'h5, 1'b1, 5'b00000, 3'd0, 16'h0000));
        vecs.push_back(mk(1'b1, 4'h6, 1'b1, 5'b00000, 3'd0, 16'h0000));
        vecs.push_back(mk(1'b0, 4'h0, 1'b0, 5'b00000, 3'd0, 16'h0000));
        vecs.push_back(mk(1'b1, 4'h7, 1'b0, 5'b10001, 3'd1, 16'h0007));
        vecs.push_back(mk(1'b1, 4'hF, 1'b0, 5'b10000, 3'd0, 16'h0000));
        // setup_on during CHECK suppresses the grant.
        vecs.push_back(mk(1'b1, 4'h1, 1'b0, 5'b10001, 3'd1, 16'h0001));
        vecs.push_back(mk(1'b1, 4'h2, 1'b0, 5'b10001, 3'd2, 16'h0012));
        vecs.push_back(mk(1'b1, 4'h3, 1'b0, 5'b10001, 3'd3, 16'h0123));
        vecs.push_back(mk(1'b1, 4'h4, 1'b0, 5'b10001, 3'd4, 16'h1234));
        vecs.push_back(mk(1'b1, 4'hE, 1'b0, 5'b10000, 3'd4, 16'h1234));
        vecs.push_back(mk(1'b0, 4'h0, 1'b1, 5'b00000, 3'd0, 16'h0000));
        vecs.push_back(mk(1'b0, 4'h0, 1'b0, 5'b00000, 3'd0, 16'h0000));
        // Wrong PIN with a key strobe during CHECK that must be dropped (try 2).
        vecs.push_back(mk(1'b1, 4'h1, 1'b0, 5'b10001, 3'd1, 16'h0001));
        vecs.push_back(mk(1'b1, 4'h2, 1'b0, 5'b10001, 3'd2, 16'h0012));
        vecs.push_back(mk(1'b1, 4'h3, 1'b0, 5'b10001, 3'd3, 16'h0123));
        vecs.push_back(mk(1'b1, 4'h5, 1'b0, 5'b10001, 3'd4, 16'h1235));
        vecs.push_back(mk(1'b1, 4'hE, 1'b0, 5'b10000, 3'd4, 16'h1235));
        vecs.push_back(mk(1'b1, 4'h7, 1'b0, 5'b00100, 3'd0, 16'h0000));
        vecs.push_back(mk(1'b0, 4'h0, 1'b0, 5'b00000, 3'd0, 16'h0000));

        // Reset state while rst is held low.
        #12;
        check("reset_state",
              32'({bip, grant, deny, locked_out, bcd_enable, digit_count, digits}), 32'd0);
        #10 rst = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            apply_vec(vecs[i], $sformatf("table[%0d]", i));
        end

        // Inactivity timeout: buffer clears exactly TIMEOUT_CYCLES after last key.
        apply_vec(mk(1'b1, 4'h1, 1'b0, 5'b10001, 3'd1, 16'h0001), "timeout_d1");
        apply_vec(mk(1'b1, 4'h2, 1'b0, 5'b10001, 3'd2, 16'h0012), "timeout_d2");
        key_valid = 1'b0;
        n = 0;
        quiet = 1'b1;
        for (int c = 1; c <= 2 * TIMEOUT_CYCLES; c++) begin
            @(posedge clk);
            #1;
            if (deny || grant || bip) quiet = 1'b0;
            if (!bcd_enable) begin
                n = c;
                break;
            end
        end
        check("timeout_len", 32'(n), 32'(TIMEOUT_CYCLES));
        check("timeout_quiet", 32'(quiet), 32'd1);
        check("timeout_clear", 32'({digit_count, digits}), 32'd0);

        // Third failure: deny and locked_out rise together, keys ignored.
        wrong_pin("third_fail", 1'b1);
        n = 1;
        quiet = 1'b1;
        for (int c = 0; c < 3 * LOCK_CYCLES; c++) begin
            key_valid = 1'b1;
            key_code  = (c % 2 == 0) ? 4'h1 : 4'hE;
            @(posedge clk);
            #1;
            if (bip || grant || deny || bcd_enable || (digit_count != 3'd0)) quiet = 1'b0;
            if (!locked_out) break;
            n++;
        end
        check("lockout_len", 32'(n), 32'(LOCK_CYCLES));
        check("lockout_quiet", 32'(quiet), 32'd1);
        good_pin("after_lockout");

        // Reset mid-entry clears the try counter: two more failures do not lock.
        wrong_pin("pre_reset_fail1", 1'b0);
        wrong_pin("pre_reset_fail2", 1'b0);
        apply_vec(mk(1'b1, 4'h1, 1'b0, 5'b10001, 3'd1, 16'h0001), "mid_entry_d1");
        apply_vec(mk(1'b1, 4'h2, 1'b0, 5'b10001, 3'd2, 16'h0012), "mid_entry_d2");
        async_reset("reset_entry");
        wrong_pin("post_reset_fail1", 1'b0);
        wrong_pin("post_reset_fail2", 1'b0);
        wrong_pin("post_reset_fail3", 1'b1);

        // Reset mid-lockout drops locked_out at once; a correct PIN then grants.
        for (int c = 0; c < 3; c++) begin
            apply_vec(mk(1'b0, 4'h0, 1'b0, 5'b00010, 3'd0, 16'h0000), $sformatf("lockout_hold[%0d]", c));
        end
        async_reset("reset_lockout");
        good_pin("after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
